// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, blank pattern and slot-phase type
// for the seven-segment scan driver.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLY_0 = 7'h01;
    localparam logic [6:0] GLY_1 = 7'h4F;
    localparam logic [6:0] GLY_2 = 7'h12;
    localparam logic [6:0] GLY_3 = 7'h06;
    localparam logic [6:0] GLY_4 = 7'h4C;
    localparam logic [6:0] GLY_5 = 7'h24;
    localparam logic [6:0] GLY_6 = 7'h20;
    localparam logic [6:0] GLY_7 = 7'h0F;
    localparam logic [6:0] GLY_8 = 7'h00;
    localparam logic [6:0] GLY_9 = 7'h04;
    localparam logic [6:0] GLY_A = 7'h08;
    localparam logic [6:0] GLY_B = 7'h60;
    localparam logic [6:0] GLY_C = 7'h31;
    localparam logic [6:0] GLY_D = 7'h42;
    localparam logic [6:0] GLY_E = 7'h30;
    localparam logic [6:0] GLY_F = 7'h38;

    typedef enum logic {
        GUARD,
        DRIVE
    } phase_e;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low
// {a,b,c,d,e,f,g} glyph lookup.
module seg_hex_decode (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    import seg_pkg::*;

    always_comb begin
        seg_o = SEG_OFF;
        unique case (nib_i)
            4'h0: seg_o = GLY_0;
            4'h1: seg_o = GLY_1;
            4'h2: seg_o = GLY_2;
            4'h3: seg_o = GLY_3;
            4'h4: seg_o = GLY_4;
            4'h5: seg_o = GLY_5;
            4'h6: seg_o = GLY_6;
            4'h7: seg_o = GLY_7;
            4'h8: seg_o = GLY_8;
            4'h9: seg_o = GLY_9;
            4'hA: seg_o = GLY_A;
            4'hB: seg_o = GLY_B;
            4'hC: seg_o = GLY_C;
            4'hD: seg_o = GLY_D;
            4'hE: seg_o = GLY_E;
            4'hF: seg_o = GLY_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-seg driver, tear-free frame loading,
// leading-zero blanking, guard interval. Define SEG_BLINK_EN for blinking.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 200000,
    parameter int GUARD_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    import seg_pkg::*;

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [TW-1:0]           tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_v_q, pend_v_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] sh_v_q, sh_v_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic       tick_end, frame_end;
    logic [3:0] nib;
    logic [6:0] glyph;
    logic       sel_dp, sel_bm, lz_blank, upper_zero, blk;
    phase_e     phase;

    always_comb begin
        tick_end  = (tick_q == TW'(REFRESH_DIV - 1));
        frame_end = tick_end && (idx_q == IW'(NUM_DIGITS - 1));
        tick_d    = tick_end ? '0 : tick_q + 1'b1;
        idx_d     = idx_q;
        if (tick_end)
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        pend_v_d  = load ? value : pend_v_q;
        pend_dp_d = load ? dp_in : pend_dp_q;
        // A load coinciding with the boundary goes straight to the shadow.
        sh_v_d    = frame_end ? pend_v_d : sh_v_q;
        sh_dp_d   = frame_end ? pend_dp_d : sh_dp_q;
        fd_d      = frame_end;
    end

    always_comb begin
        nib        = '0;
        sel_dp     = 1'b0;
        sel_bm     = 1'b0;
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (sh_v_q[4*i +: 4] == 4'h0);
            if (IW'(i) == idx_q) begin
                nib      = sh_v_q[4*i +: 4];
                sel_dp   = sh_dp_q[i];
                lz_blank = blank_lz && (i != 0) && upper_zero;
`ifdef SEG_BLINK_EN
                sel_bm   = blink_mask[i];
`endif
            end
        end
    end

    seg_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          boff_q, boff_d;

    always_comb begin
        bcnt_d = bcnt_q;
        boff_d = boff_q;
        if (frame_end) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                boff_d = ~boff_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        blk = boff_q && sel_bm;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt_q <= '0;
            boff_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            boff_q <= boff_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = (BLINK_FRAMES > 0) & sel_bm;
    assign blk          = 1'b0;
`endif

    always_comb begin
        phase = (tick_q < TW'(GUARD_CYCLES)) ? GUARD : DRIVE;
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        unique case (phase)
            GUARD: an_d = '1;
            DRIVE: begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = (lz_blank || blk) ? SEG_OFF : glyph;
                dp_d  = blk ? 1'b1 : ~sel_dp;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q    <= '0;
            idx_q     <= '0;
            pend_v_q  <= '0;
            pend_dp_q <= '0;
            sh_v_q    <= '0;
            sh_dp_q   <= '0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            pend_v_q  <= pend_v_d;
            pend_dp_q <= pend_dp_d;
            sh_v_q    <= sh_v_d;
            sh_dp_q   <= sh_dp_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed plus randomized checks of seg_scan_driver
// against a position-arithmetic display model.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int BF = 2;
    localparam int FR = N * RD;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [15:0]   value    = '0;
    logic [N-1:0]  dp_in    = '0;
    logic          load     = 1'b0;
    logic          blank_lz = 1'b0;
`ifdef SEG_BLINK_EN
    logic [N-1:0]  blink_mask = '0;
`endif
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (G),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    logic [6:0] glyph [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    // model state: cyc = counter position reached since reset release
    int           cyc;
    logic [15:0]  pend_v, sh_v;
    logic [N-1:0] pend_dp, sh_dp;
    logic [N-1:0] exp_an;
    logic [6:0]   exp_seg;
    logic         exp_dp, exp_fd;
    int           fd_cnt;
    int           fd_consec;
    logic         prev_fd;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at pos %0d: got %h expected %h",
                     nm, cyc - 1, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        pend_v  = '0;
        pend_dp = '0;
        sh_v    = '0;
        sh_dp   = '0;
        exp_an  = '1;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fd  = 1'b0;
        prev_fd = 1'b0;
    endtask

    task automatic model_step();
        int         p, tick, idx;
        logic       bnd;
        logic [6:0] s;
        logic       d;
        logic [15:0] up;
        p    = cyc;
        tick = p % RD;
        idx  = (p / RD) % N;
        bnd  = (p % FR) == FR - 1;
        if (tick < G) begin
            exp_an  = '1;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            up     = sh_v >> (4 * idx);
            exp_an = ~(N'(1) << idx);
            s      = glyph[up[3:0]];
            d      = ~sh_dp[idx];
            if (blank_lz && idx > 0 && up == 16'h0)
                s = 7'h7F;
`ifdef SEG_BLINK_EN
            if ((((p / FR) / BF) % 2) == 1 && blink_mask[idx]) begin
                s = 7'h7F;
                d = 1'b1;
            end
`endif
            exp_seg = s;
            exp_dp  = d;
        end
        exp_fd = bnd;
        if (load) begin
            pend_v  = value;
            pend_dp = dp_in;
        end
        if (bnd) begin
            sh_v  = pend_v;
            sh_dp = pend_dp;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done) fd_cnt++;
        if (frame_done && prev_fd) fd_consec++;
        prev_fd = frame_done;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to(int p);
        while (cyc <= p) cycle();
    endtask

    initial begin
        int base;
        model_reset();
        fd_cnt    = 0;
        fd_consec = 0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);
        reset = 1'b1;

        // 1234 loaded mid-frame 0, visible from frame 1
        value = 16'h1234;
        for (int n = 1; n <= 64; n++) begin
            load = (n == 5);
            cycle();
            if (n == 3) begin
                chk("first_an", 32'(an), 32'hE);
                chk("first_seg", 32'(seg), 32'h01);
            end
            if (n == 35) chk("f1_d0", 32'(seg), 32'h4C);
            if (n == 59) begin
                chk("f1_d3", 32'(seg), 32'h4F);
                chk("f1_an3", 32'(an), 32'h7);
            end
        end
        chk("fd_2frames", 32'(fd_cnt), 32'd2);
        load = 1'b0;

        // leading-zero blanking with a decimal point
        value    = 16'h00A0;
        dp_in    = 4'b0010;
        blank_lz = 1'b1;
        load     = 1'b1;
        cycle();
        load = 1'b0;
        run_to(98);
        chk("lz_d0", 32'(seg), 32'h01);
        run_to(106);
        chk("lz_d1", 32'(seg), 32'h08);
        chk("lz_dp1", 32'(dp), 32'h0);
        chk("lz_an1", 32'(an), 32'hD);
        run_to(114);
        chk("lz_d2", 32'(seg), 32'h7F);
        chk("lz_an2", 32'(an), 32'hB);
        run_to(122);
        chk("lz_d3", 32'(seg), 32'h7F);

        // load exactly on the boundary edge, then one cycle late
        run_to(126);
        blank_lz = 1'b0;
        dp_in    = 4'b0000;
        value    = 16'hBEEF;
        load     = 1'b1;
        cycle();
        value = 16'h5555;
        cycle();
        load = 1'b0;
        run_to(130);
        chk("beef_d0", 32'(seg), 32'h38);
        run_to(154);
        chk("beef_d3", 32'(seg), 32'h60);
        run_to(162);
        chk("5555_d0", 32'(seg), 32'h24);

        // frame_done cadence over three aligned frames
        run_to(191);
        fd_cnt    = 0;
        fd_consec = 0;
        run_to(191 + 3 * FR);
        chk("fd_count", 32'(fd_cnt), 32'd3);
        chk("fd_consec", 32'(fd_consec), 32'd0);

        // asynchronous reset during digit 2 DRIVE
        base = ((cyc / FR) + 1) * FR;
        run_to(base + 2 * RD + 4);
        chk("pre_rst_an", 32'(an), 32'hB);
        #2 reset = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp), 32'h1);
        chk("arst_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 1; n <= G + 1; n++) cycle();
        chk("post_rst_seg", 32'(seg), 32'h01);
        chk("post_rst_an", 32'(an), 32'hE);

`ifdef SEG_BLINK_EN
        // blink on digit 0 only
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        reset      = 1'b1;
        value      = 16'h8888;
        blink_mask = 4'b0001;
        load       = 1'b1;
        cycle();
        load = 1'b0;
        run_to(FR + G);
        chk("blk_on1", 32'(seg), 32'h00);
        run_to(2 * FR + G);
        chk("blk_off2", 32'(seg), 32'h7F);
        chk("blk_an2", 32'(an), 32'hE);
        run_to(2 * FR + RD + G);
        chk("blk_d1", 32'(seg), 32'h00);
        run_to(3 * FR + G);
        chk("blk_off3", 32'(seg), 32'h7F);
        run_to(4 * FR + G);
        chk("blk_on4", 32'(seg), 32'h00);
`endif

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp_in = N'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
`ifdef SEG_BLINK_EN
            if ($urandom_range(0, 63) == 0) blink_mask = N'($urandom);
`endif
            cycle();
        end
        chk("rand_fd_consec", 32'(fd_consec), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the board demo path. Scans NUM_DIGITS hex digits from a packed value onto shared active-low segment lines with one-hot active-low digit enables. It adds tear-free frame-synchronous loading, per-digit decimal points, leading-zero blanking and an anti-ghosting guard interval. Sits between the processor debug outputs (PC / register readout mux) and the board SSD pins.

## Interface
- NUM_DIGITS, 4: digits scanned, 2..8.
- REFRESH_DIV, 200000: clk cycles per digit slot, ≥ GUARD_CYCLES+2.
- GUARD_CYCLES, 1000: cycles at the start of each slot with all digits off, ≥ 1.
- BLINK_FRAMES, 64: frames per blink half-period (only with SEG_BLINK_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- value  in  4*NUM_DIGITS  hex data; nibble i drives digit i, digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- load  in  1  one-cycle strobe that captures value/dp_in.
- blank_lz  in  1  leading-zero blanking enable, level, sampled live.
- blink_mask  in  NUM_DIGITS  digits to blink (present only with SEG_BLINK_EN).
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse after the last slot of a frame.

## Operation
- Reset (reset=0, asynchronous): an all ones, seg 7'h7F, dp 1, frame_done 0; tick counter, digit index, pending and shadow registers all 0.
- Tick counter runs 0..REFRESH_DIV-1, then wraps. On wrap, the digit index advances; NUM_DIGITS-1 wraps to 0, which marks the frame boundary.
- Slot phases:
  - GUARD (tick < GUARD_CYCLES): an all ones, seg 7'h7F, dp 1.
  - DRIVE (remaining ticks): an[idx]=0, seg = glyph(shadow nibble idx), dp = ~shadow_dp[idx].
- Loading:
  - load=1 writes value/dp_in into the pending register.
  - At each frame boundary, shadow takes pending.
  - If load and a frame boundary coincide, shadow takes the live value/dp_in directly, and pending is updated too.
  - Displayed data therefore never changes mid-frame.
- Leading-zero blanking: when blank_lz=1, digit i>0 is blanked (seg 7'h7F, dp still honoured, an still asserted) if shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Glyphs, active-low, hex:
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
  - 8:00, 9:04, A:08, b:60, C:31, d:42, E:30, F:38
- frame_done pulses when the index wraps to 0.

## Timing
- All outputs are registered and lag the tick/index state by one clk.
- First DRIVE output appears GUARD_CYCLES+1 cycles after reset release, on digit 0. A new digit becomes visible GUARD_CYCLES+1 cycles after its slot starts.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: from load, up to one frame plus GUARD_CYCLES+1 cycles.
- Reset asserted mid-frame forces all outputs to their reset values immediately. Scanning restarts at digit 0, tick 0, and the shadow is zero (displays "0" or blanked zeros).
- load held high: each cycle overwrites pending; the last value before the boundary wins.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter toggles a blink phase every BLINK_FRAMES frames; phase resets to "on".
  - During the "off" phase, digits with blink_mask[i]=1 are blanked in DRIVE (seg 7'h7F, dp 1, an[i] still low).
  - blink_mask is sampled live.
- SEG_BLINK_EN undefined: no blink_mask port, no frame counter, and no blanking beyond leading-zero blanking.

## Structure
- Package seg_pkg holds the 16 glyph constants, SEG_OFF = 7'h7F, and the phase enum {GUARD, DRIVE}.
- One sub-module, seg_hex_decode: combinational nibble-to-glyph lookup, instantiated once on the selected nibble.
- Counter, index, load and blank logic live in the top module.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Reset, then load value=16'h1234 mid-frame 0 → frame 0 shows 0000. From frame 1: an 1110/1101/1011/0111 with seg 4C/06/12/4F, each slot 2 cycles dark then 6 cycles lit.
- Load 16'h00A0, blank_lz=1, dp_in=4'b0010 → digits 3,2 blanked (seg 7F), digit 1 seg 08 with dp=0, digit 0 seg 01.
- Load 16'hBEEF pulsed exactly at a frame boundary → the next frame shows BEEF with no intervening value. Load 16'h5555 on the cycle after → waits a full frame.
- Assert reset during digit 2 DRIVE → same cycle an=4'hF, seg=7F, dp=1, frame_done=0. After release, digit 0 shows glyph 01 at cycle GUARD_CYCLES+1.
- frame_done: exactly one pulse every 32 cycles; never two consecutive cycles.
- SEG_BLINK_EN, blink_mask=4'b0001, value 16'h8888 → digit 0 seg alternates 00 / 7F every 2 frames; digits 1–3 are constant 00.
